// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: aligns stores onto a DATA_W bus, extracts and extends loads, stalls on wait states.
// Optional bus timeout abort is enabled with the BUS_TIMEOUT_EN macro.
module mem_access_unit #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memenM,
    input  logic                memwriteM,
    input  logic [1:0]          sizeM,
    input  logic                signedM,
    input  logic                flushM,
    input  logic [ADDR_W-1:0]   addrM,
    input  logic [DATA_W-1:0]   wdataM,
    output logic [DATA_W-1:0]   rdataM,
    output logic                stallM,
    output logic                adelM,
    output logic                adesM,
    output logic                bus_errM,
    output logic                req,
    output logic                we,
    output logic [DATA_W/8-1:0] be,
    output logic [ADDR_W-1:0]   baddr,
    output logic [DATA_W-1:0]   bwdata,
    input  logic                ack,
    input  logic [DATA_W-1:0]   brdata
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned LW   = $clog2(BE_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   baddr_q, baddr_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   bwdata_q, bwdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                drop_q, drop_d;

    logic [LW-1:0]       lane_s;
    logic                misal_s;
    logic                ade_s;
    logic                issue_s;
    logic                timeout_s;
    logic [BE_W-1:0]     be_s;
    logic [DATA_W-1:0]   rep_s;
    logic [DATA_W-1:0]   shifted_s;
    logic [DATA_W-1:0]   load_s;

    assign lane_s = addrM[LW-1:0];

    // Misalignment check; dword cannot be carried by a 32-bit bus at all
    always_comb begin
        case (sizeM)
            2'd0:    misal_s = 1'b0;
            2'd1:    misal_s = lane_s[0];
            2'd2:    misal_s = (lane_s[1:0] != 2'b00);
            2'd3:    misal_s = (DATA_W == 32'd32) ? 1'b1 : (lane_s != {LW{1'b0}});
            default: misal_s = 1'b1;
        endcase
    end

    assign ade_s   = (state_q == S_IDLE) && memenM && misal_s && !flushM;
    assign issue_s = (state_q == S_IDLE) && memenM && !misal_s && !flushM;
    assign adelM   = ade_s && !memwriteM;
    assign adesM   = ade_s && memwriteM;

    // Byte-enable pattern for the requested size, shifted to the lane offset
    always_comb begin
        case (sizeM)
            2'd0:    be_s = BE_W'(1'b1) << lane_s;
            2'd1:    be_s = BE_W'(2'b11) << lane_s;
            2'd2:    be_s = BE_W'(4'hF) << lane_s;
            2'd3:    be_s = {BE_W{1'b1}};
            default: be_s = {BE_W{1'b1}};
        endcase
    end

    // Replicate right-aligned store data so every lane carries it
    always_comb begin
        rep_s = wdataM;
        case (sizeM)
            2'd0: for (int i = 0; i < int'(DATA_W / 8); i++) rep_s[i*8 +: 8] = wdataM[7:0];
            2'd1: for (int i = 0; i < int'(DATA_W / 16); i++) rep_s[i*16 +: 16] = wdataM[15:0];
            2'd2: for (int i = 0; i < int'(DATA_W / 32); i++) rep_s[i*32 +: 32] = wdataM[31:0];
            default: rep_s = wdataM;
        endcase
    end

    assign shifted_s = brdata >> {lane_q, 3'b000};

    // Load extraction: low field of the shifted word, sign or zero extended
    always_comb begin
        case (size_q)
            2'd0:    load_s = sign_q ? DATA_W'($signed(shifted_s[7:0]))  : DATA_W'(shifted_s[7:0]);
            2'd1:    load_s = sign_q ? DATA_W'($signed(shifted_s[15:0])) : DATA_W'(shifted_s[15:0]);
            2'd2:    load_s = sign_q ? DATA_W'($signed(shifted_s[31:0])) : DATA_W'(shifted_s[31:0]);
            default: load_s = shifted_s;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_errM  = bus_err_q;

    // Wait counter restarts from zero on every new request
    always_comb begin
        if (state_q == S_REQ && !ack) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (state_q == S_REQ) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
        bus_err_d = (state_q == S_REQ) && !ack && timeout_s;
    end

    // Timeout counter and one-cycle error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= {CNT_W{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign bus_errM  = 1'b0;
`endif

    // Next-state and stall logic; a flush during REQ only suppresses the writeback
    always_comb begin
        state_d  = state_q;
        baddr_d  = baddr_q;
        lane_d   = lane_q;
        size_d   = size_q;
        sign_d   = sign_q;
        we_d     = we_q;
        be_d     = be_q;
        bwdata_d = bwdata_q;
        rdata_d  = rdata_q;
        drop_d   = drop_q;
        stallM   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue_s) begin
                    state_d  = S_REQ;
                    baddr_d  = {addrM[ADDR_W-1:LW], {LW{1'b0}}};
                    lane_d   = lane_s;
                    size_d   = sizeM;
                    sign_d   = signedM;
                    we_d     = memwriteM;
                    be_d     = be_s;
                    bwdata_d = rep_s;
                    drop_d   = 1'b0;
                    stallM   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                stallM = 1'b1;
                drop_d = drop_q || flushM;
                if (ack) begin
                    state_d = S_DONE;
                    if (!we_q && !drop_q && !flushM) begin
                        rdata_d = load_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (timeout_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transaction registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            baddr_q  <= {ADDR_W{1'b0}};
            lane_q   <= {LW{1'b0}};
            size_q   <= 2'd0;
            sign_q   <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= {BE_W{1'b0}};
            bwdata_q <= {DATA_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baddr_q  <= baddr_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            we_q     <= we_d;
            be_q     <= be_d;
            bwdata_q <= bwdata_d;
            rdata_q  <= rdata_d;
            drop_q   <= drop_d;
        end
    end

    assign req    = (state_q == S_REQ);
    assign we     = we_q;
    assign be     = be_q;
    assign baddr  = baddr_q;
    assign bwdata = bwdata_q;
    assign rdataM = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance driven from a vector table and a 64-bit instance by hand.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        memen, mw, sgn, flush, ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, brdata;
    logic [31:0] rdata, baddr, bwdata;
    logic        stall, adel, ades, berr, req, we;
    logic [3:0]  be;

    logic        memen_w, mw_w, sgn_w, flush_w, ack_w;
    logic [1:0]  size_w;
    logic [31:0] addr_w, baddr_w;
    logic [63:0] wdata_w, brdata_w, rdata_w, bwdata_w;
    logic        stall_w, adel_w, ades_w, berr_w, req_w, we_w;
    logic [7:0]  be_w;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) u32 (
        .clk(clk), .rst(rst), .memenM(memen), .memwriteM(mw), .sizeM(size), .signedM(sgn),
        .flushM(flush), .addrM(addr), .wdataM(wdata), .rdataM(rdata), .stallM(stall),
        .adelM(adel), .adesM(ades), .bus_errM(berr), .req(req), .we(we), .be(be),
        .baddr(baddr), .bwdata(bwdata), .ack(ack), .brdata(brdata)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(4)) u64 (
        .clk(clk), .rst(rst), .memenM(memen_w), .memwriteM(mw_w), .sizeM(size_w), .signedM(sgn_w),
        .flushM(flush_w), .addrM(addr_w), .wdataM(wdata_w), .rdataM(rdata_w), .stallM(stall_w),
        .adelM(adel_w), .adesM(ades_w), .bus_errM(berr_w), .req(req_w), .we(we_w), .be(be_w),
        .baddr(baddr_w), .bwdata(bwdata_w), .ack(ack_w), .brdata(brdata_w)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mw;
        logic [1:0]  size;
        logic        sgn;
        logic        flush_req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        int          waits;
        logic        ade;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic run_vec(input vec_t v);
        int stall_cyc;
        int n;
        bit done;
        @(negedge clk);
        memen = 1'b1; mw = v.mw; size = v.size; sgn = v.sgn; addr = v.addr;
        wdata = v.wdata; brdata = v.brdata; flush = 1'b0; ack = 1'b0;
        #1;
        if (v.ade) begin
            chk("adelM", adel, !v.mw);
            chk("adesM", ades, v.mw);
            chk("ade_stall", stall, 1'b0);
            repeat (2) begin
                @(negedge clk); #1;
                chk("ade_no_req", req, 1'b0);
            end
            chk("ade_rdata_kept", rdata, v.rdata);
            memen = 1'b0;
            return;
        end
        chk("issue_stall", stall, 1'b1);
        chk("issue_no_ade", {adel, ades}, 2'b00);
        stall_cyc = 1;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            ack   = (n == v.waits);
            flush = v.flush_req && (n == 0);
            #1;
            if (stall) begin
                chk("req_held", req, 1'b1);
                if (n == 0) begin
                    chk("be", be, v.be);
                    chk("baddr", baddr, v.baddr);
                    chk("we", we, v.mw);
                    if (v.mw) chk("bwdata", bwdata, v.bwdata);
                end
                stall_cyc++;
                n++;
            end else begin
                done = 1'b1;
            end
        end
        chk("reached_done", done, 1'b1);
        chk("stall_cycles", stall_cyc, v.waits + 2);
        chk("rdataM", rdata, v.rdata);
        chk("done_no_req", req, 1'b0);
        memen = 1'b0; ack = 1'b0; flush = 1'b0;
    endtask

    task automatic run64(input logic w, input logic [1:0] sz, input logic s, input logic [31:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input logic ade,
                         input logic [7:0] exp_be, input logic [63:0] exp_bw, input logic [63:0] exp_rd);
        @(negedge clk);
        memen_w = 1'b1; mw_w = w; size_w = sz; sgn_w = s; addr_w = a; wdata_w = wd; brdata_w = rd;
        #1;
        if (ade) begin
            chk("w64_ade", {adel_w, ades_w}, w ? 2'b01 : 2'b10);
            chk("w64_ade_stall", stall_w, 1'b0);
            @(negedge clk); #1;
            chk("w64_ade_no_req", req_w, 1'b0);
            memen_w = 1'b0;
            return;
        end
        chk("w64_issue_stall", stall_w, 1'b1);
        @(negedge clk);
        ack_w = 1'b1;
        #1;
        chk("w64_req", req_w, 1'b1);
        chk("w64_be", be_w, exp_be);
        chk("w64_baddr", baddr_w, a & 32'hFFFF_FFF8);
        if (w) chk("w64_bwdata", bwdata_w, exp_bw);
        @(negedge clk);
        ack_w = 1'b0;
        #1;
        chk("w64_done_stall", stall_w, 1'b0);
        chk("w64_rdata", rdata_w, exp_rd);
        memen_w = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b0;
        memen = 1'b0; mw = 1'b0; size = 2'd0; sgn = 1'b0; flush = 1'b0; ack = 1'b0;
        addr = 32'h0; wdata = 32'h0; brdata = 32'h0;
        memen_w = 1'b0; mw_w = 1'b0; size_w = 2'd0; sgn_w = 1'b0; flush_w = 1'b0; ack_w = 1'b0;
        addr_w = 32'h0; wdata_w = 64'h0; brdata_w = 64'h0;

        //            mw   sz    sg   fl   addr          wdata         brdata        wt ade  be     baddr         bwdata        rdata
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 3, 1'b0, 4'h8, 32'h0000_0100, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 1'b0, 4'h8, 32'h0000_0100, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 1'b0, 32'h0000_0102, 32'h0000_1234, 32'h0,        0, 1'b0, 4'hC, 32'h0000_0100, 32'h1234_1234, 32'h0000_0080};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 1'b0, 32'h0000_0101, 32'h0000_1234, 32'h0,        0, 1'b1, 4'h0, 32'h0,         32'h0,        32'h0000_0080};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 1'b0, 32'h0000_0202, 32'h0,        32'h8001_1234, 1, 1'b0, 4'hC, 32'h0000_0200, 32'h0,        32'hFFFF_8001};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 1'b0, 32'h0000_0200, 32'h0,        32'h8001_F234, 0, 1'b0, 4'h3, 32'h0000_0200, 32'h0,        32'h0000_F234};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0000_0301, 32'h0,        32'h1122_3344, 2, 1'b0, 4'h2, 32'h0000_0300, 32'h0,        32'h0000_0033};
        vecs[8]  = '{1'b1, 2'd0, 1'b0, 1'b0, 32'h0000_0402, 32'hFFFF_FFAB, 32'h0,        0, 1'b0, 4'h4, 32'h0000_0400, 32'hABAB_ABAB, 32'h0000_0033};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 1'b0, 32'h0000_0504, 32'hCAFE_F00D, 32'h0,        1, 1'b0, 4'hF, 32'h0000_0504, 32'hCAFE_F00D, 32'h0000_0033};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 1'b0, 32'h0000_0106, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,         32'h0,        32'h0000_0033};
        vecs[11] = '{1'b0, 2'd3, 1'b0, 1'b0, 32'h0000_0108, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,         32'h0,        32'h0000_0033};
        vecs[12] = '{1'b1, 2'd2, 1'b0, 1'b0, 32'h0000_0103, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,         32'h0,        32'h0000_0033};
        vecs[13] = '{1'b0, 2'd1, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        32'h0000_7FFF, 0, 1'b0, 4'h3, 32'h0000_0200, 32'h0,        32'h0000_7FFF};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 1'b1, 32'h0000_0600, 32'h0,        32'h1234_5678, 2, 1'b0, 4'hF, 32'h0000_0600, 32'h0,        32'h0000_7FFF};
        vecs[15] = '{1'b0, 2'd2, 1'b1, 1'b0, 32'h0000_0700, 32'h0,        32'h0BAD_F00D, 0, 1'b0, 4'hF, 32'h0000_0700, 32'h0,        32'h0BAD_F00D};

        #12;
        chk("rst_req", req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_we_be", {we, be}, 5'h0);
        chk("rst_baddr", baddr, 32'h0);
        chk("rst_bwdata", bwdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_berr", berr, 1'b0);
        chk("rst_rdata64", rdata_w, 64'h0);
        rst = 1'b1;

        // flush in IDLE blocks the issue entirely
        @(negedge clk);
        memen = 1'b1; mw = 1'b0; size = 2'd2; addr = 32'h0000_0100; flush = 1'b1;
        #1;
        chk("flush_idle_stall", stall, 1'b0);
        chk("flush_idle_ade", {adel, ades}, 2'b00);
        @(negedge clk); #1;
        chk("flush_idle_no_req", req, 1'b0);
        memen = 1'b0; flush = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        run64(1'b0, 2'd3, 1'b0, 32'h0000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF);
        run64(1'b0, 2'd3, 1'b0, 32'h0000_000C, 64'h0, 64'h0, 1'b1, 8'h00, 64'h0, 64'h0);
        run64(1'b0, 2'd2, 1'b1, 32'h0000_000C, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000);
        run64(1'b0, 2'd1, 1'b0, 32'h0000_000E, 64'h0, 64'hBEEF_0000_0000_0000, 1'b0, 8'hC0, 64'h0, 64'h0000_0000_0000_BEEF);
        run64(1'b0, 2'd0, 1'b1, 32'h0000_0005, 64'h0, 64'h0000_9A00_0000_0000, 1'b0, 8'h20, 64'h0, 64'hFFFF_FFFF_FFFF_FF9A);
        run64(1'b1, 2'd2, 1'b0, 32'h0000_0004, 64'h0000_0000_CAFE_F00D, 64'h0, 1'b0, 8'hF0, 64'hCAFE_F00D_CAFE_F00D, 64'hFFFF_FFFF_FFFF_FF9A);

        // Load with no ack: timeout build aborts, default build keeps waiting
        @(negedge clk);
        memen = 1'b1; mw = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h0000_0800; ack = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt = 0;
        @(negedge clk); #1;
        while (req && cnt < 20) begin
            cnt++;
            @(negedge clk); #1;
        end
        chk("timeout_req_cycles", cnt, 4);
        chk("timeout_berr", berr, 1'b1);
        chk("timeout_stall", stall, 1'b0);
        chk("timeout_rdata_kept", rdata, 32'h0BAD_F00D);
        memen = 1'b0;
        @(negedge clk); #1;
        chk("timeout_berr_pulse", berr, 1'b0);
        chk("timeout_idle_no_req", req, 1'b0);
        @(negedge clk);
        memen = 1'b1;
`endif
        cnt = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (req && !berr) cnt++;
        end
`ifndef BUS_TIMEOUT_EN
        chk("no_ack_req_held", cnt, 20);
        chk("no_ack_stall", stall, 1'b1);
`endif
        // Asynchronous reset while the request is outstanding
        memen = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", req, 1'b0);
        chk("async_rst_stall", stall, 1'b0);
        chk("async_rst_be", be, 4'h0);
        chk("async_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_idle", req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised memory-stage load/store unit that sits between the pipeline's M stage and a request/acknowledge data bus.
- Generalises the fixed 32-bit, 4-bit byte-enable store path to a DATA_W-wide bus.
- Adds wait-state handling with a pipeline stall, load alignment with sign/zero extension, and address-error detection.

Parameters:
- DATA_W, 32, data bus width in bits; legal values 32 or 64.
- ADDR_W, 32, address width in bits.
- TIMEOUT_CYCLES, 255, cycles to wait for ack before abort; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- memenM  in  1  M-stage access valid
- memwriteM  in  1  1=store, 0=load
- sizeM  in  2  0=byte, 1=half, 2=word, 3=dword
- signedM  in  1  sign-extend load result
- flushM  in  1  kill the current access
- addrM  in  ADDR_W  byte address
- wdataM  in  DATA_W  store data, right-aligned
- rdataM  out  DATA_W  aligned and extended load result
- stallM  out  1  hold pipeline
- adelM  out  1  load address error
- adesM  out  1  store address error
- bus_errM  out  1  bus timeout (BUS_TIMEOUT_EN only; tied 0 otherwise)
- req  out  1  bus request
- we  out  1  bus write
- be  out  DATA_W/8  byte enables
- baddr  out  ADDR_W  bus address, lane bits forced 0
- bwdata  out  DATA_W  lane-replicated store data
- ack  in  1  bus acknowledge
- brdata  in  DATA_W  bus read data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. req, we, be, baddr, bwdata, rdataM, stallM, bus_errM are all 0.
- Lane offset L = addrM[log2(DATA_W/8)-1:0].
- Misalignment rules:
  - half with L[0]!=0 is misaligned;
  - word with L[1:0]!=0 is misaligned;
  - dword with L!=0 is misaligned;
  - dword when DATA_W=32 is illegal and treated as misaligned.
- Address errors: adelM/adesM are combinational and asserted only in IDLE when memenM=1, the access is misaligned and flushM=0. No bus request is issued and stallM stays 0.
- IDLE: a valid aligned access with flushM=0 registers addr, size, sign, we, be and bwdata, then moves to REQ. stallM=1 combinationally in this same cycle.
- REQ: req=1 and stallM=1, with outputs held stable until ack.
  - ack=1: capture brdata into the result register and go to DONE.
- DONE: stallM=0 and rdataM valid; return to IDLE. rdataM holds its value until the next load completes.
- Zero-wait bus (ack in the first REQ cycle): total stall is 2 cycles.
- be generation: byte→1<<L, half→3<<L, word→15<<L, dword→all ones.
- bwdata: the byte, half or word is replicated across all lanes.
- Load extraction:
  - shift brdata right by L*8;
  - take the low 8, 16, 32 or 64 bits;
  - sign-extend if signedM, else zero-extend, to DATA_W.
- Stores: rdataM is unchanged.
- Flush:
  - flushM in IDLE blocks issue.
  - flushM in REQ does not cancel the bus transaction. A sticky drop flag is set; on ack go to DONE without updating rdataM.
- ack is ignored outside REQ.
- Reset while in REQ returns to IDLE immediately and drops req.
- memenM stays high and stable while stallM=1; the pipeline guarantees this.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES:
  - drop req;
  - pulse bus_errM for 1 cycle in DONE;
  - leave rdataM unchanged.
- Undefined: no counter; bus_errM is constant 0 and REQ waits indefinitely.

Test Plan:
- DATA_W=32, load word at addr 0x100, brdata=0xDEADBEEF, ack on first REQ cycle → be=4'hF, baddr=0x100, stallM high 2 cycles, rdataM=0xDEADBEEF.
- Signed byte load at addr 0x103, brdata=0x80FF_FFFF, ack after 3 wait cycles → be=4'h8, stallM high 5 cycles, rdataM=0xFFFFFF80; same access unsigned → 0x00000080.
- Store half 0x1234 at addr 0x102 → we=1, be=4'hC, bwdata=0x12341234; halfword store at addr 0x101 → adesM=1, req never asserted, stallM=0.
- DATA_W=64, dword load at addr 0x8 → be=8'hFF, rdataM=brdata; dword at addr 0xC → adelM=1.
- Load issued, flushM=1 during REQ, ack two cycles later → req held until ack, rdataM keeps its previous value, stallM falls in DONE.
- With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never asserted → req drops after 4 REQ cycles, bus_errM pulses 1 cycle, FSM returns to IDLE; rst low mid-REQ → req=0 asynchronously.
